// File: rtl/sar_adc_ctrl.sv
// Sequencer for the successive-approximation ADC: sample phase, one binary-search trial per clock, result strobe.
// Define SAR_ADC_CTRL_GO_SYNC_EN to pass `go` through a two-flop synchronizer before edge detection.
module sar_adc_ctrl #(
  parameter int NBITS         = 5,
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             cont,
  input  logic             cmp,
  output logic             sample,
  output logic [NBITS-1:0] dac_code,
  output logic [NBITS-1:0] result,
  output logic             valid,
  output logic             busy
);

  localparam int               IDX_W    = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [1:0]       S_IDLE   = 2'd0;
  localparam logic [1:0]       S_SAMPLE = 2'd1;
  localparam logic [1:0]       S_CONV   = 2'd2;
  localparam logic [1:0]       S_DONE   = 2'd3;
  localparam logic [3:0]       CNT_LOAD = 4'(SAMPLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NBITS - 1);
  localparam logic [NBITS-1:0] MSB_CODE = NBITS'(1) << (NBITS - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NBITS-1:0] code_q, code_d;
  logic [NBITS-1:0] result_q, result_d;
  logic             go_prev_q;
  logic             go_s;
  logic             go_rise;
  logic [NBITS-1:0] trial_bit;
  logic [NBITS-1:0] next_bit;
  logic [NBITS-1:0] decided;

`ifdef SAR_ADC_CTRL_GO_SYNC_EN
  logic [1:0] go_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) go_sync_q <= '0;
    else        go_sync_q <= {go_sync_q[0], go};
  end

  assign go_s = go_sync_q[1];
`else
  assign go_s = go;
`endif

  assign go_rise   = go_s & ~go_prev_q;
  assign trial_bit = NBITS'(1) << idx_q;
  assign next_bit  = trial_bit >> 1;
  // Bits below the trial bit are always 0, so clearing the trial bit is the whole reject case.
  assign decided   = cmp ? code_q : (code_q & ~trial_bit);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    code_d   = code_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        code_d = '0;
        if (go_rise) begin
          cnt_d   = CNT_LOAD;
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_CONV;
          idx_d   = IDX_TOP;
          code_d  = MSB_CODE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_CONV: begin
        if (idx_q != '0) begin
          code_d = decided | next_bit;
          idx_d  = idx_q - IDX_W'(1);
        end else begin
          result_d = decided;
          code_d   = '0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        code_d = '0;
        if (cont) begin
          cnt_d   = CNT_LOAD;
          state_d = S_SAMPLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      code_q    <= '0;
      result_q  <= '0;
      go_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      code_q    <= code_d;
      result_q  <= result_d;
      go_prev_q <= go_s;
    end
  end

  assign sample   = (state_q == S_SAMPLE);
  assign valid    = (state_q == S_DONE);
  assign busy     = (state_q != S_IDLE);
  assign dac_code = code_q;
  assign result   = result_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Self-checking bench for sar_adc_ctrl: comparator model plus a result scoreboard.
module tb_sar_adc_ctrl;

  localparam int NBITS = 5;
  localparam int SC    = 2;
  localparam int LAT   = SC + NBITS + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             go;
  logic             cont;
  logic             cmp;
  logic             sample;
  logic             valid;
  logic             busy;
  logic [NBITS-1:0] dac_code;
  logic [NBITS-1:0] result;
  logic [NBITS-1:0] vin_code;

  int n_checks = 0;
  int n_pass   = 0;
  logic [NBITS-1:0] exp_q[$];

  sar_adc_ctrl #(.NBITS(NBITS), .SAMPLE_CYCLES(SC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .go      (go),
    .cont    (cont),
    .cmp     (cmp),
    .sample  (sample),
    .dac_code(dac_code),
    .result  (result),
    .valid   (valid),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Ideal analog core: keep the trial bit when the input is at or above the DAC level.
  assign cmp = (vin_code >= dac_code);

  task automatic test_reset();
    rst_n = 1'b0; go = 1'b0; cont = 1'b0; vin_code = '0;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if ({sample, valid, busy, dac_code, result} !== '0)
      $display("FAIL reset_outputs: got s=%b v=%b b=%b dac=%0d res=%0d, want all 0", sample, valid, busy, dac_code, result);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if ({sample, valid, busy, dac_code, result} !== '0)
      $display("FAIL idle_after_reset: got s=%b v=%b b=%b dac=%0d res=%0d, want all 0", sample, valid, busy, dac_code, result);
    else n_pass++;
  endtask

  // Mid-scale and both range extremes, one conversion each.
  task automatic test_single_shot();
    logic [NBITS-1:0] vins[3] = '{5'd19, 5'd0, 5'd31};
    for (int n = 0; n < 3; n++) begin
      logic [NBITS-1:0] v;
      logic [NBITS-1:0] exp_t;
      int               e, b, nsample, nvalid, trial_err, vi;
      v = vins[n]; vi = int'(v); vin_code = v;
      nsample = 0; nvalid = 0; trial_err = 0;
      exp_q.push_back(v);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      for (int k = 1; k <= LAT + 1; k++) begin
        if (sample) nsample++;
        if (k >= SC + 1 && k <= SC + NBITS) begin
          b = NBITS + SC - k;
          e = ((vi >> (b + 1)) << (b + 1)) | (1 << b);
          exp_t = e[NBITS-1:0];
          if (dac_code !== exp_t) begin
            trial_err++;
            $display("FAIL trial_code vin=%0d cyc=%0d: got %0d, want %0d", v, k, dac_code, exp_t);
          end
        end
        if (valid) begin
          nvalid++;
          n_checks++;
          if (k !== LAT) $display("FAIL valid_latency vin=%0d: got %0d, want %0d", v, k, LAT);
          else n_pass++;
          n_checks++;
          if (exp_q.size() == 0) $display("FAIL scoreboard_empty vin=%0d: got result %0d, want none", v, result);
          else begin
            exp_t = exp_q.pop_front();
            if (result !== exp_t) $display("FAIL result vin=%0d: got %0d, want %0d", v, result, exp_t);
            else n_pass++;
          end
        end
        @(negedge clk);
      end
      n_checks++;
      if (trial_err != 0) $display("FAIL trial_sequence vin=%0d: got %0d bad trials, want 0", v, trial_err);
      else n_pass++;
      n_checks++;
      if (nsample !== SC) $display("FAIL sample_cycles vin=%0d: got %0d, want %0d", v, nsample, SC);
      else n_pass++;
      n_checks++;
      if (nvalid !== 1) $display("FAIL valid_count vin=%0d: got %0d, want 1", v, nvalid);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0 || result !== v || dac_code !== '0)
        $display("FAIL idle_hold vin=%0d: got busy=%b res=%0d dac=%0d, want 0/%0d/0", v, busy, result, dac_code, v);
      else n_pass++;
    end
  endtask

  task automatic test_continuous();
    int first_v, second_v, nvalid, busy_low;
    logic [NBITS-1:0] exp_t;
    first_v = -1; second_v = -1; nvalid = 0; busy_low = 0;
    vin_code = 5'd19; cont = 1'b1;
    exp_q.push_back(5'd19);
    exp_q.push_back(5'd7);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int k = 1; k <= 2 * LAT + 2; k++) begin
      if (k <= 2 * LAT && busy !== 1'b1) busy_low++;
      if (valid) begin
        nvalid++;
        if (first_v < 0) first_v = k; else second_v = k;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL cont_scoreboard_empty: got result %0d, want none", result);
        else begin
          exp_t = exp_q.pop_front();
          if (result !== exp_t) $display("FAIL cont_result: got %0d, want %0d", result, exp_t);
          else n_pass++;
        end
        vin_code = 5'd7;
      end
      if (k == LAT + 1) cont = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (nvalid !== 2) $display("FAIL cont_valid_count: got %0d, want 2", nvalid);
    else n_pass++;
    n_checks++;
    if (second_v - first_v !== LAT) $display("FAIL cont_spacing: got %0d, want %0d", second_v - first_v, LAT);
    else n_pass++;
    n_checks++;
    if (busy_low !== 0) $display("FAIL cont_busy: got %0d low cycles, want 0", busy_low);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL cont_stop: got busy=%b, want 0", busy);
    else n_pass++;
  endtask

  task automatic test_ignored_go();
    int nvalid;
    logic [NBITS-1:0] exp_t;
    // Toggles during SAMPLE and CONV.
    nvalid = 0; vin_code = 5'd12;
    exp_q.push_back(5'd12);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int k = 1; k <= 3 * LAT; k++) begin
      go = (k == 1 || k == 4 || k == 6) ? 1'b1 : 1'b0;
      if (valid) begin
        nvalid++;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL toggle_scoreboard_empty: got result %0d, want none", result);
        else begin
          exp_t = exp_q.pop_front();
          if (result !== exp_t) $display("FAIL toggle_result: got %0d, want %0d", result, exp_t);
          else n_pass++;
        end
      end
      if (k == LAT + 1) go = 1'b0;
      @(negedge clk);
      if (k > LAT) go = 1'b0;
    end
    n_checks++;
    if (nvalid !== 1) $display("FAIL toggle_valid_count: got %0d, want 1", nvalid);
    else n_pass++;
    // Held high: exactly one conversion.
    nvalid = 0; vin_code = 5'd5;
    exp_q.push_back(5'd5);
    go = 1'b1;
    for (int k = 0; k < 3 * LAT; k++) begin
      @(negedge clk);
      if (valid) begin
        nvalid++;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL held_scoreboard_empty: got result %0d, want none", result);
        else begin
          exp_t = exp_q.pop_front();
          if (result !== exp_t) $display("FAIL held_result: got %0d, want %0d", result, exp_t);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (nvalid !== 1 || busy !== 1'b0) $display("FAIL held_go: got %0d valids busy=%b, want 1 valid busy=0", nvalid, busy);
    else n_pass++;
    go = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int nvalid, vlat;
    logic [NBITS-1:0] exp_t;
    vin_code = 5'd19;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int k = 1; k < SC + 3; k++) @(negedge clk);
    n_checks++;
    if (dac_code !== 5'd20) $display("FAIL third_trial: got %0d, want 20", dac_code);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({sample, valid, busy, dac_code, result} !== '0)
      $display("FAIL async_reset: got s=%b v=%b b=%b dac=%0d res=%0d, want all 0", sample, valid, busy, dac_code, result);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    nvalid = 0;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      if (valid || busy) nvalid++;
    end
    n_checks++;
    if (nvalid !== 0 || result !== '0) $display("FAIL no_partial: got %0d active cycles res=%0d, want 0/0", nvalid, result);
    else n_pass++;
    // Normal conversion after the aborted one.
    vin_code = 5'd9; nvalid = 0; vlat = -1;
    exp_q.push_back(5'd9);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      if (valid) begin
        nvalid++; vlat = k;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL post_reset_scoreboard_empty: got result %0d, want none", result);
        else begin
          exp_t = exp_q.pop_front();
          if (result !== exp_t) $display("FAIL post_reset_result: got %0d, want %0d", result, exp_t);
          else n_pass++;
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (nvalid !== 1 || vlat !== LAT) $display("FAIL post_reset_valid: got %0d valids at %0d, want 1 at %0d", nvalid, vlat, LAT);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_continuous();
    test_ignored_go();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sar_adc_ctrl.md
# sar_adc_ctrl

Digital sequencer for the on-chip 5-bit successive-approximation ADC. On a start request it drives the sample phase, runs one binary-search trial per clock against the comparator, and publishes the converted code with a one-cycle valid strobe. It sits between the `go`, `sample`, `valid` and `result` pads and the analog SAR core, which provides the comparator and capacitive DAC.

## Interface
- `NBITS`, default 5: conversion resolution and width of the DAC code and result.
- `SAMPLE_CYCLES`, default 2: cycles `sample` stays high per conversion. Legal range 1..15.
- `clk` in 1: conversion clock. Rising edge only.
- `rst_n` in 1: asynchronous, active-low reset.
- `go` in 1: start request. Acts on its rising edge.
- `cont` in 1: continuous mode. Sampled only in the DONE state.
- `cmp` in 1: comparator output from the analog core. 1 means vin ≥ current DAC trial, so the trial bit is kept.
- `sample` out 1: sample switch control. High only in SAMPLE.
- `dac_code` out NBITS: DAC trial code to the analog core. Registered.
- `result` out NBITS: last completed conversion. Held until the next completion.
- `valid` out 1: one-cycle pulse, coincident with `result` updating.
- `busy` out 1: high in every state except IDLE.

## Operation
- Reset values: state IDLE; `sample`, `valid` and `busy` are 0; `dac_code` and `result` are 0; the internal copy of the previous `go` value is 0.
- FSM states:
  - **IDLE:**
    - Outputs: `dac_code` = 0, `busy` = 0.
    - On a `go` rising edge (current 1, previous 0), load the sample counter with SAMPLE_CYCLES−1 and go to SAMPLE.
  - **SAMPLE:**
    - Outputs: `sample` = 1, `dac_code` = 0.
    - Decrement the counter each cycle. When it reaches 0, go to CONV with bit index i = NBITS−1 and `dac_code` = 1<<(NBITS−1).
  - **CONV:**
    - One trial per cycle. At the clock edge, `cmp` decides bit i: keep it if `cmp`=1, clear it if 0.
    - If i > 0, the next `dac_code` is the decided upper bits, plus bit i−1 set, with lower bits 0.
    - If i = 0, copy the decided code to `result`, set `valid`, and go to DONE.
  - **DONE:**
    - Outputs: `valid` = 1 for exactly this cycle; `dac_code` = 0.
    - If `cont`=1, reload the counter and go to SAMPLE. Otherwise go to IDLE.
- `go` edges are ignored in SAMPLE, CONV and DONE. A `go` held high through DONE does not retrigger; a new rising edge is required.
- `cmp` is ignored outside CONV.
- Asserting `rst_n` mid-conversion immediately forces all reset values, including `result` = 0. No partial result is ever published.
- Widths:
  - The bit index is clog2(NBITS) bits wide.
  - The sample counter is 4 bits wide.
  - Codes are unsigned; no arithmetic overflow is possible.

## Timing
- Let cycle t be the edge at which the `go` rising edge is detected.
- `sample` is high for cycles t+1 .. t+SAMPLE_CYCLES.
- Trial cycles are t+SAMPLE_CYCLES+1 .. t+SAMPLE_CYCLES+NBITS. `dac_code` for bit i is valid throughout its trial cycle.
- `cmp` must settle before the end of the trial cycle; it is sampled at that cycle's closing edge.
- `valid` and the new `result` appear at cycle t+SAMPLE_CYCLES+NBITS+1. Latency is SAMPLE_CYCLES+NBITS+1 cycles (8 with defaults).
- Continuous-mode throughput is one conversion per SAMPLE_CYCLES+NBITS+1 cycles.

## Configuration
- `SAR_ADC_CTRL_GO_SYNC_EN`:
  - **Defined:** `go` passes through a two-flop synchronizer, reset to 0, before edge detection. This adds 2 cycles to start latency (10 with defaults) and makes `go` safe to drive directly from an asynchronous pad.
  - **Undefined:** `go` is edge-detected directly and must be synchronous to `clk`.

## Test plan
All scenarios use defaults, sync macro undefined, and a comparator model `cmp` = (vin_code ≥ `dac_code`).
- **Mid-scale input.** vin_code=19, pulse `go` → trials 16,24,20,18,19; `valid` 8 cycles after the edge; `result`=19; `sample` high exactly 2 cycles.
- **Range extremes.** vin_code=0 → trials 16,8,4,2,1, `result`=0. vin_code=31 → trials 16,24,28,30,31, `result`=31.
- **Continuous mode.** `cont`=1, vin_code=19 then 7 → `valid` pulses exactly 8 cycles apart; results 19 then 7; `busy` stays high throughout.
- **Ignored start requests.** `go` toggled during SAMPLE and CONV → no restart; single `valid`. `go` held high → only one conversion.
- **Reset mid-conversion.** `rst_n` pulsed low during the third trial → all outputs 0 immediately, state IDLE, no `valid`. The next `go` converts normally.
- **Synchronizer enabled.** Macro defined → the same stimulus as the mid-scale case gives `valid` 10 cycles after the `go` edge.
